// File: rtl/enc_index_capture_fifo_pkg.sv
// Shared constants for the encoder index capture FIFO and its ring-buffer core.
package enc_index_capture_fifo_pkg;

    // Default index width: 4 bits for the 16x4 encoder tree.
    localparam int unsigned IDX_W_DEFAULT = 4;
    // Default queue depth; must be a power of two, at least 2.
    localparam int unsigned DEPTH_DEFAULT = 4;

    // Occupancy counter width; wide enough to hold DEPTH itself.
    function automatic int unsigned cnt_w(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_w(DEPTH_DEFAULT);

endpackage

// File: rtl/enc_sync_fifo_core.sv
// Ring-buffer FIFO: storage, read/write pointers and occupancy count.
// The caller qualifies push/pop; push while full is only legal with a
// simultaneous pop.
module enc_sync_fifo_core
    import enc_index_capture_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = IDX_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CNT_W = cnt_w(DEPTH),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for pointers and count; power-of-two depth makes the
    // pointer increment wrap from DEPTH-1 to 0 on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears every entry so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Status comes from the count, so pointer equality is never ambiguous.
    always_comb begin
        rdata = mem_q[rd_ptr_q];
        count = count_q;
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: rtl/enc_index_capture_fifo.sv
// Capture stage behind the priority-encoder tree: turns changes in the
// encoder's valid/index into events, queues the indices and lets a consumer
// drain them with valid/ready. A sticky flag records events lost to a full
// queue.
module enc_index_capture_fifo
    import enc_index_capture_fifo_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic             v_prev_q;
    logic [IDX_W-1:0] idx_prev_q;
    logic             overflow_q, overflow_d;
    logic             evt, push, pop, drop;

    // Event detect and handshake qualification. A held-steady index is one
    // event; a full queue only accepts when the head leaves the same cycle.
    always_comb begin
        evt       = v_in & (~v_prev_q | (idx_in != idx_prev_q));
        out_valid = ~empty;
        pop       = out_valid & out_ready;
        push      = evt & (~full | pop);
        drop      = evt & full & ~pop;
        // Setting beats clearing when both happen together.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Previous-sample registers for edge detection plus the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_prev_q   <= 1'b0;
            idx_prev_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            v_prev_q   <= v_in;
            idx_prev_q <= idx_in;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    enc_sync_fifo_core #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (idx_in),
        .rdata (out_idx),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_enc_index_capture_fifo.sv
// Self-checking bench for enc_index_capture_fifo: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_enc_index_capture_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_in;
    logic [3:0] idx_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_idx;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    int q[$];
    bit m_pv;
    int m_pidx;
    bit m_ovf;

    enc_index_capture_fifo #(
        .IDX_W (4),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_in      (v_in),
        .idx_in    (idx_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pv   = 1'b0;
        m_pidx = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "_valid"}, 32'(out_valid), 32'(sz > 0));
        chk({tag, "_count"}, 32'(count), 32'(sz));
        chk({tag, "_full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        if (sz > 0) begin
            chk({tag, "_idx"}, 32'(out_idx), 32'(q[0]));
        end
    endtask

    // Advance the model with the current inputs, clock once, then compare.
    task automatic tick(input string tag);
        bit v, r, c, evt, pop;
        int i, sz;
        v   = v_in;
        i   = int'(idx_in);
        r   = out_ready;
        c   = clr_ovf;
        sz  = q.size();
        evt = v && (!m_pv || i != m_pidx);
        pop = (sz > 0) && r;
        if (pop) begin
            void'(q.pop_front());
        end
        if (evt && (sz < DEPTH || pop)) begin
            q.push_back(i);
        end
        if (evt && sz == DEPTH && !pop) begin
            m_ovf = 1'b1;
        end else if (c) begin
            m_ovf = 1'b0;
        end
        m_pv   = v;
        m_pidx = i;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int exp3[4];
        int exp5[4];
        exp3 = '{3, 7, 12, 5};
        exp5 = '{7, 12, 5, 14};

        // 1: reset state
        rst = 1'b1; v_in = 1'b0; idx_in = 4'd0; out_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #12;
        check_all("t1_rst");
        chk("t1_idx0", 32'(out_idx), 32'd0);
        rst = 1'b0;
        tick("t1_idle");

        // 2: held index produces one entry
        v_in = 1'b1; idx_in = 4'd9;
        for (int k = 0; k < 5; k++) tick("t2_hold");
        chk("t2_count1", 32'(count), 32'd1);
        chk("t2_idx9", 32'(out_idx), 32'd9);

        // 3: fill with four distinct indices, then drain in order
        v_in = 1'b0; out_ready = 1'b1;
        tick("t3_flush");
        out_ready = 1'b0; v_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idx_in = 4'(exp3[k]);
            tick("t3_fill");
        end
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count4", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", 32'(out_idx), 32'(exp3[k]));
            tick("t3_drain");
        end
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: overflow on full, set beats clear, then clear alone
        out_ready = 1'b0; v_in = 1'b0;
        tick("t4_gap");
        v_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idx_in = 4'(exp3[k]);
            tick("t4_fill");
        end
        idx_in = 4'd2; clr_ovf = 1'b1;
        tick("t4_drop");
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        chk("t4_count4", 32'(count), 32'd4);
        chk("t4_head3", 32'(out_idx), 32'd3);
        tick("t4_clr");
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        clr_ovf = 1'b0;

        // 5: full with simultaneous pop and push
        idx_in = 4'd14; out_ready = 1'b1;
        tick("t5_swap");
        chk("t5_count4", 32'(count), 32'd4);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t5_order", 32'(out_idx), 32'(exp5[k]));
            tick("t5_drain");
        end

        // 6: asynchronous reset mid-stream
        out_ready = 1'b0; idx_in = 4'd1;
        tick("t6_a");
        idx_in = 4'd8;
        tick("t6_b");
        chk("t6_count2", 32'(count), 32'd2);
        rst = 1'b1;
        model_reset();
        #2;
        check_all("t6_rst");
        chk("t6_idx0", 32'(out_idx), 32'd0);
        rst = 1'b0;
        v_in = 1'b1; idx_in = 4'd6;
        tick("t6_after");
        chk("t6_idx6", 32'(out_idx), 32'd6);
        chk("t6_count1", 32'(count), 32'd1);

        // Random traffic; small index range makes repeats common
        for (int k = 0; k < 400; k++) begin
            v_in      = ($urandom_range(0, 3) != 0);
            idx_in    = 4'($urandom_range(0, 3) * 5);
            out_ready = ($urandom_range(0, 9) < 4);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
